// File: rtl/req_encoder_4to2_pkg.sv
// Shared types and defaults for the request encoder.
// Index width derives from the request count through clog2.
package req_encoder_4to2_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned IDX_W_DEF = 2;

  typedef logic [IDX_W_DEF-1:0] idx_t;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } out_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/req_encoder_4to2_prio_pick.sv
// Combinational find-first-set over a request vector, starting the search at offset and
// wrapping from the top bit back to bit 0.
module prio_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] offset,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // N_REQ is a power of two, so IDX_W-bit addition wraps naturally.
      pos = offset + IDX_W'(i);
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/req_encoder_4to2.sv
// Sequential request encoder: captures request pulses into a pending set and issues them one
// at a time as binary indices over a valid/ready handshake.
module req_encoder_4to2
  import req_encoder_4to2_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEF,
  parameter int unsigned IDX_W       = clog2(N_REQ),
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  out_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;

  logic             load;
  logic [N_REQ-1:0] load_mask;
  logic [N_REQ-1:0] req_eff;
  logic [IDX_W-1:0] offset;
  logic             found;
  logic [IDX_W-1:0] pick_idx;

  assign offset = (ROUND_ROBIN != 0) ? ptr_q + IDX_W'(1) : '0;

  prio_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec    (pending_q),
    .offset (offset),
    .found  (found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    load_mask = '0;
    load      = (state_q == StEmpty) || out_ready;
    if (load) begin
      if (found) begin
        load_mask[pick_idx] = 1'b1;
        state_d             = StFull;
        idx_d               = pick_idx;
        ptr_d               = pick_idx;
      end else begin
        state_d = StEmpty;
      end
    end
    req_eff    = enable ? req : '0;
    // New requests are OR-ed in after the clear, so set wins over clear.
    pending_d  = (pending_q & ~load_mask) | req_eff;
    overflow_d = |(req_eff & pending_q & ~load_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      idx_q      <= '0;
      ptr_q      <= IDX_W'(N_REQ - 1);
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_idx   = idx_q;
  assign out_valid = (state_q == StFull);
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Scoreboard bench: fixed-priority and round-robin instances driven with directed vectors.
module tb_req_encoder_4to2;
  import req_encoder_4to2_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, rdy0, en1, rdy1;
  logic [3:0] req0, req1;
  logic [1:0] idx0, idx1;
  logic       v0, v1, ov0, ov1;
  logic [3:0] pend0, pend1;

  idx_t q0[$];
  idx_t q1[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  req_encoder_4to2 #(.N_REQ(4), .IDX_W(2), .ROUND_ROBIN(0)) u_fixed (
    .clk(clk), .rst_n(rst_n), .enable(en0), .req(req0), .out_idx(idx0), .out_valid(v0),
    .out_ready(rdy0), .pending(pend0), .overflow(ov0)
  );

  req_encoder_4to2 #(.N_REQ(4), .IDX_W(2), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .enable(en1), .req(req1), .out_idx(idx1), .out_valid(v1),
    .out_ready(rdy1), .pending(pend1), .overflow(ov1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: an index is consumed at the edge following a negedge where valid && ready.
  always @(negedge clk) begin
    if (rst_n && v0 && rdy0) begin
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL fixed_unexpected: got idx %0d, want no output", idx0);
      end else chk("fixed_idx", int'(idx0), int'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && v1 && rdy1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL rr_unexpected: got idx %0d, want no output", idx1);
      end else chk("rr_idx", int'(idx1), int'(q1.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    en0 = 1'b1; en1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1; req0 = '0; req1 = '0;
    repeat (2) tick();
    chk("rst_pending", int'(pend0), 0);
    chk("rst_valid", int'(v0), 0);
    chk("rst_idx", int'(idx0), 0);
    chk("rst_overflow", int'(ov0), 0);
    rst_n = 1'b1;
    tick();

    // Single request: valid two edges after sampling.
    req0 = 4'b0010; q0.push_back(2'd1);
    tick(); req0 = '0;
    chk("lat_valid_early", int'(v0), 0);
    tick();
    chk("lat_valid", int'(v0), 1);
    chk("lat_idx", int'(idx0), 1);
    chk("lat_pending", int'(pend0), 0);
    tick();
    chk("lat_valid_drop", int'(v0), 0);

    // Multi-hot, fixed priority, back-to-back issue.
    req0 = 4'b1011; q0.push_back(2'd0); q0.push_back(2'd1); q0.push_back(2'd3);
    tick(); req0 = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("burst_valid", int'(v0), 1);
    end
    tick();
    chk("burst_done", int'(v0), 0);

    // Round-robin bursts; pointer wraps from 3 back to 0.
    for (int b = 0; b < 2; b++) begin
      req1 = 4'b1111;
      for (int i = 0; i < 4; i++) q1.push_back(idx_t'(i));
      tick(); req1 = '0;
      repeat (5) tick();
      chk("rr_done", int'(v1), 0);
    end
    // Pointer at 1 after this, so 4'b0101 issues 2 then 0.
    req1 = 4'b0010; q1.push_back(2'd1);
    tick(); req1 = '0;
    repeat (2) tick();
    req1 = 4'b0101; q1.push_back(2'd2); q1.push_back(2'd0);
    tick(); req1 = '0;
    repeat (3) tick();
    chk("rr_rot_done", int'(v1), 0);

    // Hold with backpressure, re-request and overflow.
    rdy0 = 1'b0;
    req0 = 4'b0100; q0.push_back(2'd2); q0.push_back(2'd2);
    tick(); req0 = '0;
    tick();
    chk("hold_idx", int'(idx0), 2);
    chk("hold_pending_clr", int'(pend0), 0);
    req0 = 4'b0100;
    tick(); req0 = '0;
    chk("hold_pending_set", int'(pend0), 4);
    chk("hold_no_ovf", int'(ov0), 0);
    req0 = 4'b0100;
    tick(); req0 = '0;
    chk("hold_ovf", int'(ov0), 1);
    chk("hold_idx2", int'(idx0), 2);
    tick();
    chk("hold_ovf_pulse", int'(ov0), 0);
    chk("hold_valid", int'(v0), 1);
    rdy0 = 1'b1;
    repeat (2) tick();
    chk("hold_done", int'(v0), 0);

    // enable=0 ignores new requests but pending still drains.
    en0 = 1'b0; req0 = 4'b1000;
    tick(); req0 = '0;
    chk("dis_pending", int'(pend0), 0);
    tick();
    chk("dis_valid", int'(v0), 0);
    en0 = 1'b1; req0 = 4'b0011; q0.push_back(2'd0); q0.push_back(2'd1);
    tick();
    en0 = 1'b0; req0 = 4'b1000;
    tick(); req0 = '0;
    chk("dis_drain_pending", int'(pend0), 2);
    repeat (2) tick();
    chk("dis_drain_done", int'(v0), 0);
    chk("dis_drain_empty", int'(pend0), 0);
    en0 = 1'b1;

    // Asynchronous reset mid-drain drops the in-flight index.
    rdy0 = 1'b0; req0 = 4'b1101;
    tick(); req0 = '0;
    tick();
    chk("pre_rst_pending", int'(pend0), 12);
    chk("pre_rst_valid", int'(v0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(v0), 0);
    chk("arst_pending", int'(pend0), 0);
    chk("arst_idx", int'(idx0), 0);
    tick();
    rst_n = 1'b1; rdy0 = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", int'(v0), 0);
    chk("post_rst_pending", int'(pend0), 0);
    req0 = 4'b1000; q0.push_back(2'd3);
    tick(); req0 = '0;
    tick();
    chk("post_rst_new_valid", int'(v0), 1);
    chk("post_rst_new_idx", int'(idx0), 3);
    repeat (2) tick();

    chk("fixed_queue_drained", q0.size(), 0);
    chk("rr_queue_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/req_encoder_4to2.md
# req_encoder_4to2

Sequential request encoder: the inverse of the 2-to-4 decoder. It captures pulsed request lines into a pending set and emits each pending request, one at a time, as a binary index over a valid/ready handshake. It sits in front of any block that consumes 2-bit select codes, such as the decoder itself, and turns simultaneous or bursty one-hot events into an ordered stream of indices.

## Interface
- `N_REQ`, default 4: number of request lines; power of two, ≥2.
- `IDX_W`, default 2: index width, equal to log2(`N_REQ`).
- `ROUND_ROBIN`, default 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin starting after the last issued index.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = accept new requests; 0 = ignore `req`. Draining continues either way.
- `req`  in  `N_REQ`  request pulses, sampled every cycle; bits may be multi-hot.
- `out_idx`  out  `IDX_W`  encoded index of the presented request; registered.
- `out_valid`  out  1  `out_idx` is valid; registered.
- `out_ready`  in  1  consumer accepts `out_idx` when `out_valid` and `out_ready` are both 1.
- `pending`  out  `N_REQ`  captured requests not yet moved to the output register.
- `overflow`  out  1  one-cycle pulse: a request arrived on a line whose pending bit was already set.

## Operation
- Reset values: `pending`=0, `out_valid`=0, `out_idx`=0, `overflow`=0, round-robin pointer = `N_REQ`-1, so index 0 is searched first.
- Capture: each cycle, `pending` is updated as `(pending & ~load_mask) | (enable ? req : 0)`. If set and clear hit the same bit, set wins.
- The output register loads when `!out_valid || out_ready`. This is the LOAD condition.
  - On LOAD with `pending != 0`: pick an index with the priority picker, write it to `out_idx`, set `out_valid`=1, and clear that bit via `load_mask`. The round-robin pointer takes the picked index.
  - On LOAD with `pending == 0`: `out_valid`=0 and `out_idx` holds its value.
- Hold: while `out_valid` is 1 and `out_ready` is 0, `out_idx` and `out_valid` stay stable. `pending` keeps accumulating.
- Overflow: `overflow` is 1 in the cycle after an edge where `enable` & `req[i]` & `pending[i]` & !`load_mask[i]`. The request merges; there is no count.
- A request on the line currently held in `out_idx` (already cleared from `pending`) is a new pending entry, not an overflow.
- Fixed priority: the lowest set bit wins. Round-robin: the first set bit at or after pointer+1, wrapping from `N_REQ`-1 to 0.
- `enable`=0 affects capture only. Pending entries still drain.
- Reset asserted mid-operation clears everything immediately. Any in-flight index is dropped and is not presented after reset.

## Timing
- Latency: `req` sampled at edge k sets `pending` at edge k. The index is loaded at edge k+1, and `out_valid` is high in the cycle after edge k+1, giving 2 cycles from request to valid.
- Throughput: with `out_ready` held at 1, one index is issued per cycle. There are no bubbles while `pending` is non-zero.
- Two-state output FSM:
  - EMPTY (`out_valid`=0) goes to FULL on LOAD with `pending` non-zero.
  - FULL goes to EMPTY on accept with `pending`=0.
  - FULL stays FULL on accept with `pending` non-zero (next index loaded), or when not accepted.
- `out_idx` changes only at an edge where LOAD is true.

## Structure
- Shared package holds the `N_REQ`/`IDX_W` defaults, an `idx_t` typedef, and a `clog2` function.
- One sub-module, `prio_pick`: combinational, `N_REQ`-bit find-first-set with a rotate offset. It returns `found` and `idx`. Fixed priority uses offset 0; round-robin uses pointer+1.
- Top level holds the `pending` register, the output register/FSM, the round-robin pointer, and the `overflow` flag.

## Test plan
- Reset, then `req`=4'b0010 for 1 cycle with `out_ready`=1 -> `out_valid` high 2 cycles later, `out_idx`=1 for one cycle, `pending`=0.
- Fixed priority, `req`=4'b1011 in one cycle, `out_ready`=1 -> indices 0, 1, 3 on consecutive cycles, then `out_valid`=0.
- `ROUND_ROBIN`=1, `req`=4'b1111 in one cycle, `out_ready`=1 -> indices 0, 1, 2, 3. Repeat the burst -> 0, 1, 2, 3 again, with the pointer wrapping.
- `out_ready`=0 with index 2 presented, then `req`=4'b0100 twice -> `out_idx` stays 2. The first pulse sets `pending[2]`; the second pulse produces one `overflow` pulse. Release `out_ready` -> index 2 is issued twice in total.
- `enable`=0 with `req`=4'b1000 -> `pending` stays 0 and no output. Earlier pending bits still drain.
- Assert `rst_n`=0 mid-drain with `pending`=4'b1100 and `out_valid`=1 -> all outputs go to 0 immediately. After release there is no output until a new request arrives.
